// File: rtl/dut_cmd_slave.sv
// Command slave: executes NOP/WR/RD/INC/CLR/RDCLR against a 16x4 register file.
// Read results leave through a valid/ready response FIFO; error and activity counters are kept.
module dut_cmd_slave #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       cmd,
   input  logic [3:0]       adr,
   input  logic [3:0]       data,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [3:0]       resp_adr,
   output logic [3:0]       resp_data,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic [15:0]      cmd_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0] OCC_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef struct packed {
      logic [3:0] adr;
      logic [3:0] data;
   } resp_t;

   logic [15:0][3:0]  mem_q, mem_d;
   resp_t             fifo_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]       occ_q, occ_d;
   resp_t             head_q, head_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  drop_q, drop_d, ill_q, ill_d;
   logic [15:0]       cmd_cnt_q, cmd_cnt_d;
   logic              is_rd, is_legal, is_ill, pop, push_ok;
   resp_t             push_ent;

   always_comb begin
      is_legal = (cmd >= 4'd1) && (cmd <= 4'd5);
      is_ill   = (cmd >= 4'd6);
      is_rd    = (cmd == 4'd2) || (cmd == 4'd5);
      pop      = (occ_q != '0) && resp_ready;
      // A full FIFO still takes the push when the head leaves in the same cycle
      push_ok  = is_rd && ((occ_q != OCC_FULL) || pop);
      push_ent = '{adr: adr, data: mem_q[adr]};

      mem_d = mem_q;
      case (cmd)
         4'd1:       mem_d[adr] = data;
         4'd3:       mem_d[adr] = mem_q[adr] + 4'd1;
         4'd4, 4'd5: mem_d[adr] = 4'd0;
         default:    ;
      endcase

      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      occ_d    = occ_q;
      if (push_ok && !pop)      occ_d = occ_q + OCC_ONE;
      else if (!push_ok && pop) occ_d = occ_q - OCC_ONE;

      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (is_rd && !push_ok) begin
         ovf_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + CNT_ONE;
      end
      ill_d = ill_q;
      if (is_ill && (ill_q != '1)) ill_d = ill_q + CNT_ONE;
      cmd_cnt_d = is_legal ? cmd_cnt_q + 16'd1 : cmd_cnt_q;

      // Registered head: the pushed entry lands at the new read pointer only when it becomes the sole entry
      head_d = head_q;
      if (occ_d != '0)
         head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_ent : fifo_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         head_q    <= '0;
         ovf_q     <= 1'b0;
         drop_q    <= '0;
         ill_q     <= '0;
         cmd_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         head_q    <= head_d;
         ovf_q     <= ovf_d;
         drop_q    <= drop_d;
         ill_q     <= ill_d;
         cmd_cnt_q <= cmd_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push_ok) fifo_q[wr_ptr_q] <= push_ent;
   end

   assign resp_valid  = (occ_q != '0);
   assign resp_adr    = head_q.adr;
   assign resp_data   = head_q.data;
   assign overflow    = ovf_q;
   assign drop_cnt    = drop_q;
   assign illegal_cnt = ill_q;
   assign cmd_cnt     = cmd_cnt_q;
endmodule

// File: tb/tb_dut_cmd_slave.sv
// Directed bench for dut_cmd_slave: inputs driven and outputs checked on the falling edge.
module tb_dut_cmd_slave;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] cmd, adr, data;
   logic       resp_valid, resp_ready;
   logic [3:0] resp_adr, resp_data;
   logic       overflow;
   logic [7:0] drop_cnt, illegal_cnt;
   logic [15:0] cmd_cnt;

   int checks = 0;
   int failures = 0;

   localparam logic [3:0] NOP = 4'd0, WR = 4'd1, RD = 4'd2, INC = 4'd3, CLR = 4'd4, RDCLR = 4'd5;

   dut_cmd_slave #(.DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .adr(adr), .data(data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_adr(resp_adr), .resp_data(resp_data), .overflow(overflow),
      .drop_cnt(drop_cnt), .illegal_cnt(illegal_cnt), .cmd_cnt(cmd_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one command and return at the falling edge after it was sampled
   task automatic cyc(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d, input logic r);
      cmd = c; adr = a; data = d; resp_ready = r;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(WR, 4'd1, 4'd1, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic chk_head(input string tag, input logic [3:0] a, input logic [3:0] d);
      chk({tag, "_vld"}, resp_valid, 1);
      chk({tag, "_adr"}, resp_adr, a);
      chk({tag, "_dat"}, resp_data, d);
   endtask

   initial begin
      rst_n = 1'b0; cmd = WR; adr = 4'd5; data = 4'd9; resp_ready = 1'b0;
      // 1: reset with WR driven, then read everything back
      @(negedge clk);
      cyc(WR, 4'd5, 4'd9, 1'b0);
      chk("rst_vld", resp_valid, 0);
      chk("rst_adr", resp_adr, 0);
      chk("rst_dat", resp_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_ill", illegal_cnt, 0);
      chk("rst_cmd", cmd_cnt, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc(RD, 4'(i), 4'd0, 1'b1);
         chk_head($sformatf("rd0_%0d", i), 4'(i), 4'd0);
      end
      cyc(NOP, 4'd0, 4'd0, 1'b1);
      chk("rd0_empty", resp_valid, 0);
      chk("rd0_hold", resp_adr, 15);
      chk("rd0_cnt", cmd_cnt, 16);

      // 2: write then read, single-cycle response
      do_reset();
      cyc(WR, 4'd5, 4'd9, 1'b1);
      chk("wr_novld", resp_valid, 0);
      cyc(RD, 4'd5, 4'd0, 1'b1);
      chk_head("wr_rd", 4'd5, 4'd9);
      cyc(NOP, 4'd0, 4'd0, 1'b1);
      chk("wr_rd_one", resp_valid, 0);
      chk("wr_cnt", cmd_cnt, 2);

      // 3: INC wrap and RDCLR ordering
      cyc(WR, 4'd3, 4'd15, 1'b1);
      cyc(INC, 4'd3, 4'd0, 1'b1);
      cyc(RDCLR, 4'd3, 4'd0, 1'b1);
      chk_head("inc_rdclr", 4'd3, 4'd0);
      cyc(RD, 4'd3, 4'd0, 1'b1);
      chk_head("inc_rd", 4'd3, 4'd0);
      cyc(WR, 4'd3, 4'd7, 1'b1);
      chk("inc_empty", resp_valid, 0);
      cyc(RDCLR, 4'd3, 4'd0, 1'b1);
      chk_head("rdclr7", 4'd3, 4'd7);
      cyc(RD, 4'd3, 4'd0, 1'b1);
      chk_head("rdclr_after", 4'd3, 4'd0);
      cyc(CLR, 4'd3, 4'd0, 1'b1);
      chk("clr_empty", resp_valid, 0);

      // 4: overflow with stalled consumer
      for (int i = 0; i < 6; i++) cyc(WR, 4'(i), 4'(i + 8), 1'b0);
      for (int i = 0; i < 6; i++) cyc(RD, 4'(i), 4'd0, 1'b0);
      chk_head("ovf_head", 4'd0, 4'd8);
      chk("ovf_flag", overflow, 1);
      chk("ovf_drop", drop_cnt, 2);
      for (int k = 1; k <= 3; k++) begin
         cyc(NOP, 4'd0, 4'd0, 1'b1);
         chk_head($sformatf("drain_%0d", k), 4'(k), 4'(k + 8));
      end
      cyc(NOP, 4'd0, 4'd0, 1'b1);
      chk("drain_empty", resp_valid, 0);
      chk("drain_hold", resp_adr, 3);

      // 5: push into full FIFO with simultaneous pop
      for (int i = 0; i < 4; i++) cyc(RD, 4'(i), 4'd0, 1'b0);
      chk("full_drop", drop_cnt, 2);
      cyc(RD, 4'd4, 4'd0, 1'b1);
      chk("fullpop_drop", drop_cnt, 2);
      chk_head("fullpop_h1", 4'd1, 4'd9);
      for (int k = 2; k <= 4; k++) begin
         cyc(NOP, 4'd0, 4'd0, 1'b1);
         chk_head($sformatf("fullpop_h%0d", k), 4'(k), 4'(k + 8));
      end
      cyc(NOP, 4'd0, 4'd0, 1'b1);
      chk("fullpop_empty", resp_valid, 0);

      // 6: illegal-opcode saturation, then reset with pending responses
      do_reset();
      cyc(WR, 4'd7, 4'd6, 1'b0);
      for (int i = 0; i < 300; i++) begin
         cyc(4'(6 + (i % 10)), 4'(i % 16), 4'd15, 1'b0);
         if (i == 253) chk("ill_254", illegal_cnt, 254);
      end
      chk("ill_sat", illegal_cnt, 255);
      chk("ill_cmdcnt", cmd_cnt, 1);
      chk("ill_novld", resp_valid, 0);
      cyc(RD, 4'd7, 4'd0, 1'b0);
      chk_head("ill_mem7", 4'd7, 4'd6);
      cyc(RD, 4'd2, 4'd0, 1'b0);
      chk("pend_cnt", cmd_cnt, 3);
      rst_n = 1'b0;
      cyc(RD, 4'd7, 4'd0, 1'b0);
      rst_n = 1'b1;
      chk("mid_vld", resp_valid, 0);
      chk("mid_adr", resp_adr, 0);
      chk("mid_dat", resp_data, 0);
      chk("mid_ill", illegal_cnt, 0);
      chk("mid_cmd", cmd_cnt, 0);
      chk("mid_ovf", overflow, 0);
      chk("mid_drop", drop_cnt, 0);
      cyc(NOP, 4'd0, 4'd0, 1'b0);
      chk("mid_ignored", resp_valid, 0);
      cyc(RD, 4'd7, 4'd0, 1'b1);
      chk_head("mid_mem7", 4'd7, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dut_cmd_slave.md
# dut_cmd_slave

Command-executing slave that sits directly downstream of the `dut_if` bus. It samples `cmd`/`adr`/`data` on every rising edge of `clk` and executes each command against a 16-entry × 4-bit register array. Read results are returned through a small response FIFO with a valid/ready handshake. The block also keeps error and activity counters, so the coverage bins on `cmd`/`adr` correspond to observable architectural effects.

## Interface
- `DEPTH`, default 4: response FIFO depth. Must be a power of two, ≥2.
- `CNT_W`, default 8: width of `drop_cnt` and `illegal_cnt`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd`  in  4  command opcode, sampled every cycle.
- `adr`  in  4  target register index 0..15.
- `data`  in  4  write operand.
- `resp_valid`  out  1  FIFO non-empty.
- `resp_ready`  in  1  consumer accepts head entry when `resp_valid`=1.
- `resp_adr`  out  4  address of the head read response.
- `resp_data`  out  4  data of the head read response.
- `overflow`  out  1  sticky flag: a read response was dropped.
- `drop_cnt`  out  CNT_W  number of dropped read responses, saturating.
- `illegal_cnt`  out  CNT_W  number of illegal opcodes, saturating.
- `cmd_cnt`  out  16  number of legal non-NOP commands executed, wrapping.

## Operation
- **Opcodes**
  - 0 NOP: no effect.
  - 1 WR: `mem[adr] <= data`.
  - 2 RD: push `{adr, mem[adr]}` into the FIFO.
  - 3 INC: `mem[adr] <= mem[adr]+1`, 4-bit wrap (15→0).
  - 4 CLR: `mem[adr] <= 0`.
  - 5 RDCLR: push `{adr, mem[adr]}` (pre-clear value) into the FIFO and clear `mem[adr]` in the same cycle.
  - 6..15 illegal: no state change except `illegal_cnt`.
- One command per cycle. There is no backpressure on the command side; the slave never stalls.
- A RD/RDCLR targeting an address modified by the previous cycle's command returns the updated value.
- **Counters**
  - `cmd_cnt` increments on opcodes 1..5.
  - `illegal_cnt` increments on opcodes 6..15 and sticks at 2^CNT_W−1.
- **FIFO**
  - Push happens on RD/RDCLR. Pop happens when `resp_valid && resp_ready`.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the push is dropped: `overflow` goes to 1, `drop_cnt` increments (saturating), and `mem` is still updated for RDCLR.
  - Push and pop in the same cycle on an empty FIFO: the push is not bypassed. The entry becomes visible the next cycle, and the pop is a no-op because `resp_valid` was 0.
  - Pointers wrap modulo DEPTH. An occupancy counter (width log2(DEPTH)+1) distinguishes full from empty.
  - `resp_adr`/`resp_data` reflect the head entry while valid. They hold their last value while empty (0 after reset).
- **Reset** (`rst_n`=0 at a rising edge)
  - `mem` cleared to 0, FIFO emptied, `overflow`=0, all counters 0, `resp_adr`/`resp_data`=0, `resp_valid`=0.
  - The command sampled in the reset cycle is ignored.
  - Reset mid-stream discards pending responses with no handshake.

## Timing
- Write latency: a WR sampled at edge N is visible to a RD sampled at edge N+1.
- Read latency: RD sampled at edge N → `resp_valid`=1 after edge N (observable in cycle N+1) if the FIFO was empty.
- Pop takes effect at the edge where `resp_valid && resp_ready`. The next entry, or `resp_valid`=0, follows in the next cycle.
- `overflow`, `drop_cnt`, `illegal_cnt` and `cmd_cnt` update at the edge the command is sampled.
- No combinational path from `cmd`/`adr`/`data`/`resp_ready` to any output.

## Test plan
1. Reset with `rst_n`=0 for 2 cycles, cmd=1 driven throughout → all outputs 0. RD of every address after release returns 0.
2. WR adr=5 data=9, then RD adr=5 with `resp_ready`=1 → one response: `resp_adr`=5, `resp_data`=9, `resp_valid` high for exactly 1 cycle. `cmd_cnt`=2.
3. WR adr=3 data=15, INC adr=3, RDCLR adr=3, RD adr=3 → responses 0 then 0 in order (INC wraps to 0 before RDCLR reads it). Then WR 3=7, RDCLR 3, RD 3 → responses 7 then 0.
4. `resp_ready`=0, 6 consecutive RDs of adr 0..5 (DEPTH=4) → FIFO holds adr 0..3. `overflow`=1, `drop_cnt`=2. Then `resp_ready`=1 drains 0,1,2,3 on consecutive cycles.
5. FIFO full with `resp_ready`=1 and a RD in the same cycle → push accepted, `drop_cnt` unchanged, occupancy stays 4.
6. Drive cmd=9 for 300 cycles (CNT_W=8) → `illegal_cnt`=255, `cmd_cnt`=0, `mem` unchanged. Assert `rst_n` mid-stream with 2 pending responses → FIFO empty, all counters 0 next cycle.
